// File: rtl/efuse_aen_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : efuse_aen_seq_if
// Brief   : Register-file / eFuse-macro signal bundle for the AEN sequencer.
// Revision: 1.0
// ============================================================================
interface efuse_aen_seq_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 10,
  parameter int BSEL_W = $clog2(DATA_W)
);
  logic              rg_efuse_reg_mode;
  logic              rg_efuse_refresh;
  logic              rg_efuse_pgmen;
  logic              rg_efuse_rden;
  logic              rg_efuse_aen;
  logic [ADDR_W-1:0] rg_efuse_addr;
  logic [DATA_W-1:0] rg_efuse_wdata;
  logic [CNT_W-1:0]  rg_efuse_tsu;
  logic [CNT_W-1:0]  rg_efuse_tpgm;
  logic [CNT_W-1:0]  rg_efuse_trd;
  logic              efuse_aen;
  logic [ADDR_W-1:0] efuse_addr_o;
  logic [BSEL_W-1:0] efuse_bitsel;
  logic              rg_efuse_aen_busy;
  logic              rg_efuse_aen_done;
  logic              rg_efuse_aen_err;

  modport master (
    output rg_efuse_reg_mode, rg_efuse_refresh, rg_efuse_pgmen, rg_efuse_rden,
           rg_efuse_aen, rg_efuse_addr, rg_efuse_wdata, rg_efuse_tsu,
           rg_efuse_tpgm, rg_efuse_trd,
    input  efuse_aen, efuse_addr_o, efuse_bitsel, rg_efuse_aen_busy,
           rg_efuse_aen_done, rg_efuse_aen_err
  );

  modport slave (
    input  rg_efuse_reg_mode, rg_efuse_refresh, rg_efuse_pgmen, rg_efuse_rden,
           rg_efuse_aen, rg_efuse_addr, rg_efuse_wdata, rg_efuse_tsu,
           rg_efuse_tpgm, rg_efuse_trd,
    output efuse_aen, efuse_addr_o, efuse_bitsel, rg_efuse_aen_busy,
           rg_efuse_aen_done, rg_efuse_aen_err
  );
endinterface
`default_nettype wire

// File: rtl/efuse_aen_seq.sv
`default_nettype none
// ============================================================================
// Module  : efuse_aen_seq
// Brief   : eFuse AEN strobe sequencer (read / per-bit program, manual bypass).
// Revision: 1.0
// ============================================================================
module efuse_aen_seq #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 10,
  parameter int BSEL_W = $clog2(DATA_W)
) (
  input  logic clk,
  input  logic rst_n,
  efuse_aen_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_NEXT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pgm_q, pgm_d;
  logic [BSEL_W-1:0] bitsel_q, bitsel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              aen_q, aen_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              last_valid_q, last_valid_d;
  logic              refresh_d1_q;

  logic              mode_ok_w;
  logic              refresh_rise_w;
  logic              start_w;
  logic              abort_w;
  logic              suppress_w;
  logic [CNT_W-1:0]  tsu_lim_w;
  logic [CNT_W-1:0]  thi_w;
  logic [CNT_W-1:0]  thi_lim_w;
  logic              last_bit_w;
  logic [BSEL_W-1:0] bitsel_inc_w;

  assign mode_ok_w      = bus.rg_efuse_pgmen ^ bus.rg_efuse_rden;
  assign refresh_rise_w = bus.rg_efuse_refresh & ~refresh_d1_q;
  assign start_w        = (state_q == S_IDLE) & bus.rg_efuse_reg_mode & refresh_rise_w & mode_ok_w;
  assign abort_w        = (state_q != S_IDLE) & (~mode_ok_w | ~bus.rg_efuse_reg_mode);
  assign suppress_w     = ~bus.rg_efuse_pgmen & last_valid_q & (bus.rg_efuse_addr == last_addr_q);

  // Zero-valued timing registers behave as one cycle
  assign tsu_lim_w    = (bus.rg_efuse_tsu == '0) ? '0 : bus.rg_efuse_tsu - CNT_W'(1);
  assign thi_w        = pgm_q ? bus.rg_efuse_tpgm : bus.rg_efuse_trd;
  assign thi_lim_w    = (thi_w == '0) ? '0 : thi_w - CNT_W'(1);
  assign last_bit_w   = (bitsel_q == BSEL_W'(DATA_W - 1));
  assign bitsel_inc_w = bitsel_q + BSEL_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pgm_d        = pgm_q;
    bitsel_d     = bitsel_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    aen_d        = aen_q;
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (refresh_rise_w && !mode_ok_w) begin
          last_valid_d = 1'b0;
        end
        if (start_w) begin
          addr_d   = bus.rg_efuse_addr;
          wdata_d  = bus.rg_efuse_wdata;
          pgm_d    = bus.rg_efuse_pgmen;
          bitsel_d = '0;
          err_d    = 1'b0;
          if (suppress_w) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            done_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = (!bus.rg_efuse_pgmen || bus.rg_efuse_wdata[0]) ? S_SETUP : S_NEXT;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == tsu_lim_w) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          aen_d   = 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == thi_lim_w) begin
          aen_d = 1'b0;
          cnt_d = '0;
          if (pgm_q) begin
            state_d = S_NEXT;
          end else begin
            state_d      = S_IDLE;
            last_addr_d  = addr_q;
            last_valid_d = 1'b1;
            done_d       = 1'b1;
            busy_d       = 1'b0;
          end
        end
      end
      S_NEXT: begin
        cnt_d = '0;
        if (last_bit_w) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          bitsel_d = bitsel_inc_w;
          state_d  = wdata_q[bitsel_inc_w] ? S_SETUP : S_NEXT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Losing a valid mode or register control mid-sequence kills the pulse
    if (abort_w) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      aen_d        = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b1;
      last_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pgm_q        <= 1'b0;
      bitsel_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      aen_q        <= 1'b0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      refresh_d1_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      pgm_q        <= pgm_d;
      bitsel_q     <= bitsel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      aen_q        <= aen_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
      refresh_d1_q <= bus.rg_efuse_refresh;
    end
  end

  assign bus.efuse_aen         = (!busy_q && !mode_ok_w) ? bus.rg_efuse_aen : aen_q;
  assign bus.efuse_addr_o      = addr_q;
  assign bus.efuse_bitsel      = bitsel_q;
  assign bus.rg_efuse_aen_busy = busy_q;
  assign bus.rg_efuse_aen_done = done_q;
  assign bus.rg_efuse_aen_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_efuse_aen_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_efuse_aen_seq
// Brief   : Directed self-checking bench for efuse_aen_seq.
// Revision: 1.0
// ============================================================================
module tb_efuse_aen_seq;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 10;
  localparam int BSEL_W = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int         t_cycles;
  int         t_highs;
  int         t_pulses;
  int         t_first;
  logic [2:0] t_bs [0:7];

  efuse_aen_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .BSEL_W(BSEL_W)) bus ();

  efuse_aen_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .BSEL_W(BSEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {16'd0, bus.efuse_aen, bus.efuse_addr_o, bus.efuse_bitsel,
            bus.rg_efuse_aen_busy, bus.rg_efuse_aen_done, bus.rg_efuse_aen_err};
  endfunction

  // Pulse refresh; returns just after the start edge
  task automatic kick();
    bus.rg_efuse_refresh = 1'b1;
    step(1);
    bus.rg_efuse_refresh = 1'b0;
  endtask

  // Count cycles, AEN-high cycles and pulses until done, bounded by maxc
  task automatic trace(input string tag, input int maxc);
    logic prev;
    prev     = 1'b0;
    t_cycles = 0;
    t_highs  = 0;
    t_pulses = 0;
    t_first  = -1;
    while (bus.rg_efuse_aen_done !== 1'b1 && t_cycles < maxc) begin
      if (bus.efuse_aen === 1'b1) begin
        t_highs++;
        if (!prev) begin
          if (t_pulses < 8) t_bs[t_pulses] = bus.efuse_bitsel;
          if (t_first < 0) t_first = t_cycles;
          t_pulses++;
        end
      end
      prev = bus.efuse_aen;
      step(1);
      t_cycles++;
    end
    chk({tag, "_done_seen"}, {31'd0, bus.rg_efuse_aen_done}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.rg_efuse_reg_mode = 1'b1;
    bus.rg_efuse_refresh  = 1'b0;
    bus.rg_efuse_pgmen    = 1'b0;
    bus.rg_efuse_rden     = 1'b1;
    bus.rg_efuse_aen      = 1'b0;
    bus.rg_efuse_addr     = 8'h12;
    bus.rg_efuse_wdata    = 8'h00;
    bus.rg_efuse_tsu      = 10'd2;
    bus.rg_efuse_tpgm     = 10'd4;
    bus.rg_efuse_trd      = 10'd3;
    step(2);
    chk("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Read 0x12, tsu=2 trd=3
    kick();
    chk("rd_busy", {31'd0, bus.rg_efuse_aen_busy}, 32'd1);
    chk("rd_addr", {24'd0, bus.efuse_addr_o}, 32'h12);
    trace("rd", 30);
    chk("rd_cycles", t_cycles, 5);
    chk("rd_highs", t_highs, 3);
    chk("rd_first_high", t_first, 2);
    chk("rd_pulses", t_pulses, 1);
    chk("rd_end_busy_aen", {30'd0, bus.rg_efuse_aen_busy, bus.efuse_aen}, 32'd0);

    // Repeat read of same address is suppressed
    step(2);
    kick();
    chk("rpt_done_busy_aen", {29'd0, bus.rg_efuse_aen_done, bus.rg_efuse_aen_busy, bus.efuse_aen}, 32'b100);
    step(3);
    chk("rpt_no_pulse", {31'd0, bus.efuse_aen}, 32'd0);

    // New address pulses normally
    bus.rg_efuse_addr = 8'h13;
    kick();
    trace("rd13", 30);
    chk("rd13_cycles", t_cycles, 5);
    chk("rd13_highs", t_highs, 3);

    // Program 1000_0101, tsu=1 tpgm=4
    bus.rg_efuse_rden  = 1'b0;
    bus.rg_efuse_pgmen = 1'b1;
    bus.rg_efuse_addr  = 8'h30;
    bus.rg_efuse_wdata = 8'b1000_0101;
    bus.rg_efuse_tsu   = 10'd1;
    step(2);
    kick();
    trace("pgm", 60);
    chk("pgm_cycles", t_cycles, 23);
    chk("pgm_highs", t_highs, 12);
    chk("pgm_pulses", t_pulses, 3);
    chk("pgm_bitsel", {23'd0, t_bs[0], t_bs[1], t_bs[2]}, {23'd0, 3'd0, 3'd2, 3'd7});
    step(2);
    chk("pgm_hold", {21'd0, bus.efuse_addr_o, bus.efuse_bitsel}, {21'd0, 8'h30, 3'd7});

    // Zero word: NEXT walk only
    bus.rg_efuse_wdata = 8'h00;
    kick();
    chk("zero_bitsel_reset", {29'd0, bus.efuse_bitsel}, 32'd0);
    trace("zero", 30);
    chk("zero_cycles", t_cycles, 8);
    chk("zero_highs", t_highs, 0);

    // Zero timings act as one cycle each
    bus.rg_efuse_wdata = 8'b0000_0011;
    bus.rg_efuse_tsu   = 10'd0;
    bus.rg_efuse_tpgm  = 10'd0;
    step(1);
    kick();
    trace("t0", 30);
    chk("t0_cycles", t_cycles, 12);
    chk("t0_highs", t_highs, 2);
    chk("t0_pulses", t_pulses, 2);
    chk("t0_first_high", t_first, 1);

    // Abort mid-HIGH by dropping pgmen
    bus.rg_efuse_wdata = 8'hFF;
    bus.rg_efuse_tsu   = 10'd1;
    bus.rg_efuse_tpgm  = 10'd4;
    bus.rg_efuse_addr  = 8'h20;
    step(1);
    kick();
    for (int i = 0; i < 20 && bus.efuse_aen !== 1'b1; i++) step(1);
    step(1);
    chk("abort_in_high", {31'd0, bus.efuse_aen}, 32'd1);
    bus.rg_efuse_pgmen = 1'b0;
    step(1);
    chk("abort_state", {28'd0, bus.efuse_aen, bus.rg_efuse_aen_busy, bus.rg_efuse_aen_done, bus.rg_efuse_aen_err},
        32'b0001);

    // Read of last address after abort is not suppressed
    bus.rg_efuse_rden = 1'b1;
    bus.rg_efuse_addr = 8'h13;
    bus.rg_efuse_tsu  = 10'd2;
    bus.rg_efuse_trd  = 10'd3;
    step(1);
    kick();
    chk("post_abort_err_clr", {31'd0, bus.rg_efuse_aen_err}, 32'd0);
    trace("post_abort", 30);
    chk("post_abort_highs", t_highs, 3);
    chk("post_abort_cycles", t_cycles, 5);

    // Manual pass-through
    bus.rg_efuse_rden = 1'b0;
    bus.rg_efuse_aen  = 1'b1;
    #1;
    chk("manual_hi", {31'd0, bus.efuse_aen}, 32'd1);
    bus.rg_efuse_aen = 1'b0;
    #1;
    chk("manual_lo", {31'd0, bus.efuse_aen}, 32'd0);
    bus.rg_efuse_aen = 1'b1;
    #1;
    chk("manual_hi2", {31'd0, bus.efuse_aen}, 32'd1);
    bus.rg_efuse_aen = 1'b0;
    step(1);

    // Asynchronous reset during a HIGH pulse
    bus.rg_efuse_rden = 1'b1;
    bus.rg_efuse_addr = 8'h44;
    step(1);
    kick();
    for (int i = 0; i < 20 && bus.efuse_aen !== 1'b1; i++) step(1);
    chk("rst_pre_high", {31'd0, bus.efuse_aen}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", all_outs(), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
